ext_irq_ctrl: RTL
=================

// Module: ext_irq_ctrl
// PURPOSE
//  Wishbone-slave external interrupt controller hanging off the core's others_wb_* master port.
//  Gathers NUM_SRC asynchronous device interrupt lines and drives the core's meip input.
//  Software uses memory-mapped registers to enable sources, claim the winning source ID, and complete it.
// PARAMETERS
//  NUM_SRC      8   number of interrupt sources; IDs are 1..NUM_SRC, ID 0 = none (max 31)
//  WB_DATA_LEN  32  wishbone data width; word-addressed registers
//  ADDR_LEN     32  wishbone address width; only adr[7:2] decoded (interconnect does base select)
//  ID_W         5   claim ID width, >= clog2(NUM_SRC+1)
// PORTS
//  clk        in   1              core clock
//  rstn       in   1              asynchronous active-low reset
//  wb_cyc_i   in   1              bus cycle
//  wb_stb_i   in   1              strobe
//  wb_we_i    in   1              1 = write
//  wb_adr_i   in   ADDR_LEN       byte address
//  wb_dat_i   in   WB_DATA_LEN    write data
//  wb_sel_i   in   WB_DATA_LEN/8  byte enables
//  wb_ack_o   out  1              single-cycle acknowledge
//  wb_dat_o   out  WB_DATA_LEN    read data, valid while wb_ack_o=1
//  irq_i      in   NUM_SRC        raw device interrupts, asynchronous; bit k = ID k+1
//  meip_o     out  1              machine external interrupt pending, to core meip
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, meip_o=0; ENABLE=0, TYPE=0 (level), all gateways IDLE, synchronisers cleared.
//  Input sync: 2-flop synchroniser per irq_i bit. Edge detection uses sync output vs. 1-cycle-delayed copy (rising edge).
//  Bus: when cyc&stb&!ack, register the access and assert ack for exactly 1 cycle on the next edge. Ack is forced low
//   in the following cycle, so minimum spacing is 2 cycles per access. Writes honour wb_sel_i on ENABLE/TYPE/PRIO/THRESH.
//  Register map (adr[7:0]):
//   0x00 PENDING RO; 0x04 ENABLE RW; 0x08 TYPE RW (1=edge, 0=level); 0x0C CLAIM read / COMPLETE write.
//   0x10 PRIO RW and 0x14 THRESH RW exist only with the macro. Unmapped: read 0, write ignored, still acked.
//  Gateway FSM per source: IDLE -> PEND when trigger occurs (level high, or rising edge) -> INSVC on claim of its ID.
//   INSVC -> IDLE on COMPLETE write with matching ID.
//  Edge sources: an edge arriving in PEND or INSVC sets a 1-deep 'again' flag. On complete, the source goes to PEND
//   next cycle and the flag clears. Further edges are lost.
//  Level sources: level is not latched. When still high at complete, the source re-enters PEND next cycle.
//   If the level drops while in PEND, the source returns to IDLE.
//  Winner: lowest ID among PEND & ENABLE. CLAIM read returns the winner ID in bits [ID_W-1:0] (upper bits 0) and moves
//   that source to INSVC in the ack cycle. With no winner it returns 0 and changes no state.
//  COMPLETE write with an ID that is 0, out of range, or not INSVC is ignored.
//  meip_o registered: next = |(PEND & ENABLE [& prio>thresh]). One cycle of lag after the state change.
//  Simultaneous events: claim and a new edge on the same source in the same cycle -> claim wins, edge sets 'again'.
//   Complete and a level still high in the same cycle -> IDLE then PEND on the following cycle.
//  Disabling a PEND source keeps it PEND (visible in PENDING) but excludes it from winner and meip.
//  Reset mid-access: ack drops immediately, no register update occurs, all state returns to reset values.
// CONFIGURATION
//  EXT_IRQ_PRIORITY_EN defined:
//   - adds a 3-bit priority per source (PRIO at 0x10, packed 4 bits/source, low 3 used) and a 3-bit THRESH (0x14).
//   - winner = highest priority, ties -> lowest ID; a source is eligible only if prio > THRESH; prio 0 never interrupts.
//   - PRIO resets to 1 and THRESH to 0, so reset behaviour matches the undefined build.
//  Undefined: fixed lowest-ID-wins arbitration; 0x10/0x14 behave as unmapped.
// STRUCTURE
//  params.vh: register offsets (EXT_IRQ_PENDING_OFF..THRESH_OFF), gateway state encodings (IDLE/PEND/INSVC).
//  Sub-module ext_irq_gateway, generated once per source: synchroniser, edge detect, FSM, 'again' flag.
//   Outputs pend/insvc; inputs claim/complete strobes and type bit.
//  Top level holds the register file, arbiter (combinational priority encode), bus FSM and meip flop.
// TESTING
//  1 Level src 3 high, ENABLE=0x04 -> meip_o=1 within 4 clk of irq_i; CLAIM read=3; meip_o=0; COMPLETE 3 with line
//    low -> PENDING=0.
//  2 Edge srcs 2 and 5 pulse same cycle, ENABLE=0xFF, TYPE=0x12 -> CLAIM=2, then CLAIM=5, then CLAIM=0 with no state change.
//  3 Edge src 1 claimed, 2 more pulses during INSVC -> COMPLETE 1 -> exactly one re-pend; next claim=1, then CLAIM=0.
//  4 COMPLETE 4 while src 4 PEND (not INSVC), and COMPLETE 0 -> ignored; PENDING bit 3 stays set; every access acks in 1 cycle.
//  5 EXT_IRQ_PRIORITY_EN: src1 prio1, src6 prio5, THRESH=4 -> CLAIM=6; THRESH=5 -> meip_o=0.
//  6 rstn low during an ENABLE write cycle -> ack low, ENABLE=0, meip_o=0; accesses after release behave normally.

Source files
------------

// File: rtl/ext_irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register offsets
// and gateway state encoding.
// Optional feature macro: EXT_IRQ_PRIORITY_EN (adds PRIO/THRESH registers).
package ext_irq_ctrl_pkg;

    localparam logic [7:0] EXT_IRQ_PENDING_OFF = 8'h00;
    localparam logic [7:0] EXT_IRQ_ENABLE_OFF  = 8'h04;
    localparam logic [7:0] EXT_IRQ_TYPE_OFF    = 8'h08;
    localparam logic [7:0] EXT_IRQ_CLAIM_OFF   = 8'h0C;
    localparam logic [7:0] EXT_IRQ_PRIO_OFF    = 8'h10;
    localparam logic [7:0] EXT_IRQ_THRESH_OFF  = 8'h14;

    typedef enum logic [1:0] {
        GW_IDLE  = 2'd0,
        GW_PEND  = 2'd1,
        GW_INSVC = 2'd2
    } gw_state_t;

    // Word-aligned byte offset from the decoded address bits adr[7:2].
    function automatic logic [7:0] word_off(input logic [5:0] adr_w);
        return {adr_w, 2'b00};
    endfunction

endpackage

// File: rtl/ext_irq_ctrl_gateway.sv
// Per-source interrupt gateway: 2-flop synchroniser, rising-edge detect,
// IDLE/PEND/INSVC state machine and a 1-deep 'again' flag for edge sources.
// Unaffected by the EXT_IRQ_PRIORITY_EN macro.
module ext_irq_ctrl_gateway
    import ext_irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic i_irq,
    input  logic i_type,      // 1 = edge, 0 = level
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pend,
    output logic o_insvc
);

    logic      r_sync0, r_sync1, r_sync_d;
    logic      r_again, w_again_nxt;
    gw_state_t r_state, w_state_nxt;
    logic      w_edge;

    assign w_edge  = i_type & r_sync1 & ~r_sync_d;
    assign o_pend  = (r_state == GW_PEND);
    assign o_insvc = (r_state == GW_INSVC);

    // Synchronise the asynchronous line and keep a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync0  <= i_irq;
            r_sync1  <= r_sync0;
            r_sync_d <= r_sync1;
        end
    end

    // Gateway state and 'again' flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= GW_IDLE;
            r_again <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_again <= w_again_nxt;
        end
    end

    // Next-state logic; a held 'again' re-pends the source one cycle after completion.
    always_comb begin
        w_state_nxt = r_state;
        w_again_nxt = r_again & i_type;
        case (r_state)
            GW_IDLE: begin
                if (r_again || w_edge || (!i_type && r_sync1)) begin
                    w_state_nxt = GW_PEND;
                    w_again_nxt = 1'b0;
                end
            end
            GW_PEND: begin
                if (i_claim)
                    w_state_nxt = GW_INSVC;
                else if (!i_type && !r_sync1)
                    w_state_nxt = GW_IDLE;
                if (w_edge)
                    w_again_nxt = 1'b1;
            end
            GW_INSVC: begin
                if (i_complete)
                    w_state_nxt = GW_IDLE;
                if (w_edge)
                    w_again_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = GW_IDLE;
                w_again_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// Wishbone-slave external interrupt controller: register file, winner
// arbitration, single-cycle bus acknowledge and the registered meip output.
// Optional feature macro: EXT_IRQ_PRIORITY_EN adds per-source priority (PRIO)
// and a threshold (THRESH); PRIO packs 4 bits per source, so with the macro
// NUM_SRC*4 must not exceed WB_DATA_LEN.
module ext_irq_ctrl
    import ext_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int WB_DATA_LEN = 32,
    parameter int ADDR_LEN    = 32,
    parameter int ID_W        = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [ADDR_LEN-1:0]      wb_adr_i,
    input  logic [WB_DATA_LEN-1:0]   wb_dat_i,
    input  logic [WB_DATA_LEN/8-1:0] wb_sel_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_LEN-1:0]   wb_dat_o,
    input  logic [NUM_SRC-1:0]       irq_i,
    output logic                     meip_o
);

    logic                   r_ack;
    logic [WB_DATA_LEN-1:0] r_dat;
    logic [NUM_SRC-1:0]     r_enable;
    logic [NUM_SRC-1:0]     r_type;
    logic                   r_meip;

    logic                   w_access;
    logic [7:0]             w_off;
    logic                   w_claim_rd;
    logic                   w_cpl_wr;
    logic [NUM_SRC-1:0]     w_pend, w_insvc, w_elig, w_claim, w_complete;
    logic [ID_W-1:0]        w_win_id;
    logic [WB_DATA_LEN-1:0] w_rdata, w_wmask;
    logic                   w_unused;

    assign w_access   = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_off      = word_off(wb_adr_i[7:2]);
    assign w_claim_rd = w_access & ~wb_we_i & (w_off == EXT_IRQ_CLAIM_OFF) & (w_win_id != '0);
    assign w_cpl_wr   = w_access & wb_we_i & (w_off == EXT_IRQ_CLAIM_OFF);
    assign w_unused   = ^{wb_adr_i[ADDR_LEN-1:8], wb_adr_i[1:0]};

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign meip_o   = r_meip;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_gw
        // Complete only reaches a source that is in service; ID 0 or out of range matches nothing.
        assign w_claim[k]    = w_claim_rd & (w_win_id == ID_W'(k + 1));
        assign w_complete[k] = w_cpl_wr & w_insvc[k] & (wb_dat_i == WB_DATA_LEN'(k + 1));

        ext_irq_ctrl_gateway u_gw (
            .clk        (clk),
            .rstn       (rstn),
            .i_irq      (irq_i[k]),
            .i_type     (r_type[k]),
            .i_claim    (w_claim[k]),
            .i_complete (w_complete[k]),
            .o_pend     (w_pend[k]),
            .o_insvc    (w_insvc[k])
        );
    end

`ifdef EXT_IRQ_PRIORITY_EN
    logic [2:0] r_prio [NUM_SRC];
    logic [2:0] r_thresh;
    logic [2:0] w_best;

    // Priority and threshold registers; priorities reset to 1 so reset behaviour matches the fixed build.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_SRC; k++) r_prio[k] <= 3'd1;
            r_thresh <= 3'd0;
        end else if (w_access && wb_we_i) begin
            if (w_off == EXT_IRQ_PRIO_OFF) begin
                for (int k = 0; k < NUM_SRC; k++)
                    if (wb_sel_i[k/2]) r_prio[k] <= wb_dat_i[4*k +: 3];
            end
            if (w_off == EXT_IRQ_THRESH_OFF && wb_sel_i[0])
                r_thresh <= wb_dat_i[2:0];
        end
    end

    // Winner: highest priority above threshold, ties resolved to the lowest ID.
    always_comb begin
        w_win_id = '0;
        w_best   = 3'd0;
        w_elig   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_elig[k] = w_pend[k] & r_enable[k] & (r_prio[k] > r_thresh);
            if (w_elig[k] && (w_win_id == '0 || r_prio[k] > w_best)) begin
                w_win_id = ID_W'(k + 1);
                w_best   = r_prio[k];
            end
        end
    end
`else
    // Winner: lowest-numbered pending and enabled source.
    always_comb begin
        w_elig   = w_pend & r_enable;
        w_win_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (w_elig[k]) w_win_id = ID_W'(k + 1);
    end
`endif

    // Read multiplexer and byte-lane write mask.
    always_comb begin
        w_rdata = '0;
        w_wmask = '0;
        for (int b = 0; b < WB_DATA_LEN / 8; b++)
            w_wmask[8*b +: 8] = {8{wb_sel_i[b]}};
        case (w_off)
            EXT_IRQ_PENDING_OFF: w_rdata = WB_DATA_LEN'(w_pend);
            EXT_IRQ_ENABLE_OFF:  w_rdata = WB_DATA_LEN'(r_enable);
            EXT_IRQ_TYPE_OFF:    w_rdata = WB_DATA_LEN'(r_type);
            EXT_IRQ_CLAIM_OFF:   w_rdata = WB_DATA_LEN'(w_win_id);
`ifdef EXT_IRQ_PRIORITY_EN
            EXT_IRQ_PRIO_OFF: begin
                for (int k = 0; k < NUM_SRC; k++)
                    w_rdata[4*k +: 4] = {1'b0, r_prio[k]};
            end
            EXT_IRQ_THRESH_OFF:  w_rdata = WB_DATA_LEN'(r_thresh);
`endif
            default:             w_rdata = '0;
        endcase
    end

    // Bus access: one-cycle ack, read data capture, ENABLE/TYPE writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_enable <= '0;
            r_type   <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= (w_access && !wb_we_i) ? w_rdata : '0;
            if (w_access && wb_we_i) begin
                if (w_off == EXT_IRQ_ENABLE_OFF)
                    r_enable <= NUM_SRC'((WB_DATA_LEN'(r_enable) & ~w_wmask) | (wb_dat_i & w_wmask));
                if (w_off == EXT_IRQ_TYPE_OFF)
                    r_type <= NUM_SRC'((WB_DATA_LEN'(r_type) & ~w_wmask) | (wb_dat_i & w_wmask));
            end
        end
    end

    // Registered meip, one cycle behind the gateway states.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_meip <= 1'b0;
        else       r_meip <= |w_elig;
    end

endmodule
